mode_timekeeper: RTL and testbench
==================================

# mode_timekeeper

Parametrised N-channel timekeeping core that replaces the fixed clock/timer/stopwatch set and its 2-bit select counter with one uniform counter channel array. Each channel is an independent up-counter (clock/stopwatch) or down-counter (timer) with run/stop, clear and field-edit controls. A button-driven selector picks which channel is shown. Sits between the debouncers and ms clock divider on one side and the BCD conversion/VGA display on the other.

## Interface
Parameters:
- N_CH, 4: number of channels, 2..8
- HR_W, 5: hour field width
- HR_MAX, 23: largest hour value; the hour field wraps at HR_MAX+1
- SUB_MAX, 99: largest sub-second value; tick rate is (SUB_MAX+1) Hz
- DOWN_MASK, 'b0100: bit i set means channel i counts down

Ports (TW = HR_W+19):
- clk  in  1  system clock; single clock domain
- reset  in  1  asynchronous, active-low reset
- tick  in  1  one-cycle strobe, one per sub-second unit
- sel_next  in  1  one-cycle pulse; advances the selected channel
- run_toggle  in  1  one-cycle pulse; toggles run on the selected channel
- clear  in  1  one-cycle pulse; zeroes and stops the selected channel
- inc_one  in  1  one-cycle pulse; adds 1 to the edited field
- inc_ten  in  1  one-cycle pulse; adds 10 to the edited field
- field  in  2  edited field: 0 sub, 1 sec, 2 min, 3 hr
- sel  out  $clog2(N_CH)  selected channel index
- disp_time  out  TW  selected channel value, packed {hr[HR_W], min[6], sec[6], sub[7]}
- running  out  N_CH  per-channel run state
- expired  out  N_CH  one-cycle pulse when a down channel reaches zero

## Operation
- Reset: every channel value is 0, running = 0, expired = 0, sel = 0.
- Selector: each sel_next pulse increments sel. sel wraps from N_CH-1 to 0.
- Commands always act on the sel value from before the edge. If sel_next arrives in the same cycle as a command, the command applies to the old channel.
- Up channel on tick while running: sub+1. Carry into sec at SUB_MAX, into min at 59, into hr at 59. The value HR_MAX:59:59:SUB_MAX wraps to all-zero. The channel keeps running and expired is not pulsed.
- Down channel on tick while running: decrement with borrow, using the same field limits.
  - When the value goes from 00:00:00:01 to zero, the channel stops (running clears) and expired[i] pulses for one cycle.
  - A down channel at zero ignores run_toggle and stays stopped.
- run_toggle: flips running[sel], subject to the zero rule above.
- clear: sets the value to zero and running[sel] to 0. If clear and run_toggle arrive together, clear wins and the channel ends stopped.
- inc_one / inc_ten:
  - Accepted only while the selected channel is stopped; ignored while it is running.
  - Arithmetic is modulo the field limit (SUB_MAX+1, 60, 60, HR_MAX+1), with no carry into the next field.
  - If both arrive together, they add 11.
- Ticks are dropped for stopped channels. All running channels advance on the same tick, independent of sel.
- A field value above its limit is never produced.

## Timing
- Every register updates on the rising clk edge on which the input pulse or tick is sampled. All inputs are synchronous to clk and already debounced.
- disp_time and sel are combinational from registers, with no extra latency. A value or sel change is visible in the cycle after the causing edge.
- expired[i] is asserted in the cycle after the tick edge that reaches zero, and for exactly one cycle.
- If reset is asserted mid-count, outputs clear immediately and asynchronously, and counting resumes on the first tick after release.

## Structure
- Package tk_pkg holds:
  - the field enum (F_SUB, F_SEC, F_MIN, F_HR)
  - the field widths 7/6/6
  - a packed time struct
  - mod-add and borrow/carry helper functions
- Sub-module tk_channel holds one channel's value, run flag, direction and expire logic. The top generates N_CH instances, taking the direction of each from DOWN_MASK[i], and contains the selector and command decode.
- Target size is 150-300 lines in total.

## Test plan
- Up carry: set ch0 to 23:59:59:98, run, apply 2 ticks. Required: disp_time = 00:00:00:00, running[0] stays 1, no expired pulse.
- Down expire: on ch2 set sec = 0, sub = 2, run, apply 2 ticks. Required: value 0, running[2] = 0, expired[2] high for exactly 1 cycle. A following run_toggle leaves running[2] = 0.
- Field edit wrap: on stopped ch1 with sec = 55, field = 1, pulse inc_ten. Required: sec = 05, min unchanged. Pulse inc_one and inc_ten together on sub = 95. Required: sub = 06.
- Selector and priority:
  - Four sel_next pulses return sel to 0.
  - sel_next together with clear clears the old channel only.
  - clear together with run_toggle leaves the channel stopped at zero.
- Edit lockout and parallel run: with ch0 and ch3 running, inc_one on ch0 is ignored, and both channels advance on each tick while sel = 1.
- Async reset: assert reset mid-count between edges. Required: all outputs are 0 before the next clk edge.

Source files
------------

// File: rtl/tk_pkg.sv
// Shared types and field arithmetic for the timekeeper channel array.
// Field helpers work on 8-bit values wide enough for any field.
package tk_pkg;

  typedef enum logic [1:0] {
    F_SUB = 2'd0,
    F_SEC = 2'd1,
    F_MIN = 2'd2,
    F_HR  = 2'd3
  } field_e;

  localparam int SUB_W = 7;
  localparam int SEC_W = 6;
  localparam int MIN_W = 6;

  typedef struct packed {
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
    logic [SUB_W-1:0] sub;
  } tk_lo_t;

  // v < lim and a <= 11, so two conditional subtractions cover every limit >= 6
  function automatic logic [7:0] mod_add(input logic [7:0] v, input logic [3:0] a,
                                         input logic [8:0] lim);
    logic [8:0] s;
    s = {1'b0, v} + {5'd0, a};
    if (s >= lim) s = s - lim;
    if (s >= lim) s = s - lim;
    return s[7:0];
  endfunction

  // Returns {carry_or_borrow, next}; passes v through untouched when en is low
  function automatic logic [8:0] step_field(input logic [7:0] v, input logic [7:0] max,
                                            input logic en, input logic down);
    logic [8:0] r;
    if (!en)
      r = {1'b0, v};
    else if (down)
      r = (v == 8'd0) ? {1'b1, max} : {1'b0, v - 8'd1};
    else
      r = (v == max) ? {1'b1, 8'd0} : {1'b0, v + 8'd1};
    return r;
  endfunction

endpackage

// File: rtl/tk_channel.sv
// One timekeeping channel: value, run flag, fixed count direction and expiry pulse.
// Commands arrive already qualified by the selector in the top.
module tk_channel
  import tk_pkg::*;
#(
  parameter int   HR_W    = 5,
  parameter int   HR_MAX  = 23,
  parameter int   SUB_MAX = 99,
  parameter logic DOWN    = 1'b0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic             i_toggle,
  input  logic             i_clear,
  input  logic [3:0]       i_amt,
  input  logic [1:0]       i_field,
  output logic [HR_W+18:0] o_value,
  output logic             o_running,
  output logic             o_expired
);

  logic [HR_W-1:0] r_hr;
  tk_lo_t          r_lo;
  logic            r_run;
  logic            r_exp;

  logic [8:0]      w_sub_s, w_sec_s, w_min_s, w_hr_s;
  logic            w_zero, w_step_zero;
  logic [HR_W-1:0] w_ed_hr;
  tk_lo_t          w_ed_lo;

  assign w_sub_s = step_field({1'b0, r_lo.sub}, 8'(SUB_MAX), 1'b1, DOWN);
  assign w_sec_s = step_field({2'b0, r_lo.sec}, 8'd59, w_sub_s[8], DOWN);
  assign w_min_s = step_field({2'b0, r_lo.min}, 8'd59, w_sec_s[8], DOWN);
  assign w_hr_s  = step_field(8'(r_hr), 8'(HR_MAX), w_min_s[8], DOWN);

  assign o_value   = {r_hr, r_lo};
  assign o_running = r_run;
  assign o_expired = r_exp;

  assign w_zero      = (o_value == '0);
  assign w_step_zero = ~|{w_hr_s, w_min_s[7:0], w_sec_s[7:0], w_sub_s[7:0]};

  // Field edits wrap inside the field and never carry into a neighbour
  always_comb begin
    w_ed_lo = r_lo;
    w_ed_hr = r_hr;
    unique case (field_e'(i_field))
      F_SUB: w_ed_lo.sub = 7'(mod_add({1'b0, r_lo.sub}, i_amt, 9'(SUB_MAX + 1)));
      F_SEC: w_ed_lo.sec = 6'(mod_add({2'b0, r_lo.sec}, i_amt, 9'd60));
      F_MIN: w_ed_lo.min = 6'(mod_add({2'b0, r_lo.min}, i_amt, 9'd60));
      F_HR:  w_ed_hr     = HR_W'(mod_add(8'(r_hr), i_amt, 9'(HR_MAX + 1)));
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hr  <= '0;
      r_lo  <= '0;
      r_run <= 1'b0;
      r_exp <= 1'b0;
    end else begin
      r_exp <= 1'b0;
      if (i_clear) begin
        r_hr  <= '0;
        r_lo  <= '0;
        r_run <= 1'b0;
      end else if (i_tick && r_run) begin
        r_hr     <= w_hr_s[HR_W-1:0];
        r_lo.min <= w_min_s[5:0];
        r_lo.sec <= w_sec_s[5:0];
        r_lo.sub <= w_sub_s[6:0];
        if (DOWN && w_step_zero) begin
          r_run <= 1'b0;
          r_exp <= 1'b1;
        end else if (i_toggle) begin
          r_run <= 1'b0;
        end
      end else begin
        // A down channel parked at zero has nothing to count and refuses to start
        if (i_toggle && !(DOWN && w_zero)) r_run <= ~r_run;
        if (!r_run && (i_amt != 4'd0)) begin
          r_hr <= w_ed_hr;
          r_lo <= w_ed_lo;
        end
      end
    end
  end

endmodule

// File: rtl/mode_timekeeper.sv
// N-channel timekeeper: channel array plus the display selector and command decode.
// Commands always address the channel selected before the current edge.
module mode_timekeeper
  import tk_pkg::*;
#(
  parameter int              N_CH      = 4,
  parameter int              HR_W      = 5,
  parameter int              HR_MAX    = 23,
  parameter int              SUB_MAX   = 99,
  parameter logic [N_CH-1:0] DOWN_MASK = 'b0100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tick,
  input  logic                    sel_next,
  input  logic                    run_toggle,
  input  logic                    clear,
  input  logic                    inc_one,
  input  logic                    inc_ten,
  input  logic [1:0]              field,
  output logic [$clog2(N_CH)-1:0] sel,
  output logic [HR_W+18:0]        disp_time,
  output logic [N_CH-1:0]         running,
  output logic [N_CH-1:0]         expired
);

  localparam int SEL_W = $clog2(N_CH);
  localparam int TW    = HR_W + 19;

  logic [SEL_W-1:0] r_sel;
  logic [3:0]       w_amt;
  logic [TW-1:0]    w_val [N_CH];

  assign w_amt = (inc_one ? 4'd1 : 4'd0) + (inc_ten ? 4'd10 : 4'd0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      r_sel <= '0;
    else if (sel_next)
      r_sel <= (r_sel == SEL_W'(N_CH - 1)) ? '0 : r_sel + 1'b1;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic w_hit;
    assign w_hit = (r_sel == SEL_W'(g));

    tk_channel #(
      .HR_W    (HR_W),
      .HR_MAX  (HR_MAX),
      .SUB_MAX (SUB_MAX),
      .DOWN    (DOWN_MASK[g])
    ) u_ch (
      .i_clk     (clk),
      .i_rst_n   (reset),
      .i_tick    (tick),
      .i_toggle  (run_toggle & w_hit),
      .i_clear   (clear & w_hit),
      .i_amt     (w_hit ? w_amt : 4'd0),
      .i_field   (field),
      .o_value   (w_val[g]),
      .o_running (running[g]),
      .o_expired (expired[g])
    );
  end

  assign sel       = r_sel;
  assign disp_time = w_val[r_sel];

endmodule

// File: tb/tb_mode_timekeeper.sv
// Bench for mode_timekeeper: directed scenarios plus random traffic against a
// model that keeps each channel as a single count of sub-second units.
module tb_mode_timekeeper;

  localparam int S = 100;
  localparam int P = 24 * 3600 * S;

  logic        clk, reset, tick, sel_next, run_toggle, clear, inc_one, inc_ten;
  logic [1:0]  field;
  logic [1:0]  sel;
  logic [23:0] disp_time;
  logic [3:0]  running, expired;

  int total = 0;
  int bad   = 0;

  int mt   [4];
  bit mrun [4];
  bit mexp [4];
  int msel;

  mode_timekeeper dut (
    .clk(clk), .reset(reset), .tick(tick), .sel_next(sel_next),
    .run_toggle(run_toggle), .clear(clear), .inc_one(inc_one), .inc_ten(inc_ten),
    .field(field), .sel(sel), .disp_time(disp_time), .running(running), .expired(expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] pack_t(input int t);
    int u, s, m, h;
    u = t % S;
    s = (t / S) % 60;
    m = (t / (S * 60)) % 60;
    h = t / (S * 3600);
    return {h[4:0], m[5:0], s[5:0], u[6:0]};
  endfunction

  function automatic int edit_t(input int t, input int f, input int amt);
    int u, s, m, h;
    u = t % S;
    s = (t / S) % 60;
    m = (t / (S * 60)) % 60;
    h = t / (S * 3600);
    case (f)
      0:       u = (u + amt) % S;
      1:       s = (s + amt) % 60;
      2:       m = (m + amt) % 60;
      default: h = (h + amt) % 24;
    endcase
    return ((h * 60 + m) * 60 + s) * S + u;
  endfunction

  function automatic logic [3:0] run_v();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = mrun[i];
    return r;
  endfunction

  function automatic logic [3:0] exp_v();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = mexp[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mt[i] = 0; mrun[i] = 0; mexp[i] = 0;
    end
    msel = 0;
  endtask

  task automatic model_step(input bit tk, sn, rt, cl, i1, i10, input int fld);
    int amt;
    amt = (i1 ? 1 : 0) + (i10 ? 10 : 0);
    for (int c = 0; c < 4; c++) begin
      bit pr, hit, dn;
      int pt;
      pr = mrun[c]; pt = mt[c]; hit = (c == msel); dn = (c == 2);
      mexp[c] = 0;
      if (hit && cl) begin
        mt[c] = 0; mrun[c] = 0;
      end else begin
        if (hit && rt && !(dn && pt == 0)) mrun[c] = !pr;
        if (tk && pr) begin
          if (!dn) mt[c] = (pt + 1) % P;
          else begin
            mt[c] = pt - 1;
            if (mt[c] == 0) begin mrun[c] = 0; mexp[c] = 1; end
          end
        end else if (hit && !pr && amt != 0) begin
          mt[c] = edit_t(pt, fld, amt);
        end
      end
    end
    if (sn) msel = (msel + 1) % 4;
  endtask

  task automatic cyc(input bit tk, sn, rt, cl, i1, i10, input int fld);
    tick = tk; sel_next = sn; run_toggle = rt; clear = cl;
    inc_one = i1; inc_ten = i10; field = 2'(fld);
    model_step(tk, sn, rt, cl, i1, i10, fld);
    @(posedge clk); #1;
    tick = 0; sel_next = 0; run_toggle = 0; clear = 0; inc_one = 0; inc_ten = 0;
  endtask

  // Field assumed to start at zero on a stopped channel
  task automatic set_field(input int fld, input int v);
    int cur;
    cur = 0;
    while (cur < v) begin
      if (v - cur >= 10) begin cyc(0, 0, 0, 0, 0, 1, fld); cur += 10; end
      else begin cyc(0, 0, 0, 0, 1, 0, fld); cur += 1; end
    end
  endtask

  task automatic test_reset();
    reset = 0; tick = 0; sel_next = 0; run_toggle = 0; clear = 0;
    inc_one = 0; inc_ten = 0; field = 0;
    model_reset();
    #12;
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL reset_sel got %0d want 0", sel); end
    total++; if (disp_time !== 24'd0) begin bad++; $display("FAIL reset_disp got %h want 0", disp_time); end
    total++; if (running !== 4'd0) begin bad++; $display("FAIL reset_running got %b want 0000", running); end
    total++; if (expired !== 4'd0) begin bad++; $display("FAIL reset_expired got %b want 0000", expired); end
    @(negedge clk); reset = 1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    total++; if (disp_time !== 24'd0) begin bad++; $display("FAIL post_reset_disp got %h want 0", disp_time); end
  endtask

  task automatic test_up_carry();
    set_field(3, 23); set_field(2, 59); set_field(1, 59); set_field(0, 98);
    total++; if (disp_time !== {5'd23, 6'd59, 6'd59, 7'd98})
      begin bad++; $display("FAIL up_preset got %h want %h", disp_time, {5'd23, 6'd59, 6'd59, 7'd98}); end
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    total++; if (disp_time !== {5'd23, 6'd59, 6'd59, 7'd99})
      begin bad++; $display("FAIL up_tick1 got %h want %h", disp_time, {5'd23, 6'd59, 6'd59, 7'd99}); end
    cyc(1, 0, 0, 0, 0, 0, 0);
    total++; if (disp_time !== 24'd0) begin bad++; $display("FAIL up_wrap got %h want 0", disp_time); end
    total++; if (running[0] !== 1'b1) begin bad++; $display("FAIL up_wrap_run got %b want 1", running[0]); end
    total++; if (expired !== 4'd0) begin bad++; $display("FAIL up_wrap_exp got %b want 0000", expired); end
    cyc(0, 0, 0, 1, 0, 0, 0);
  endtask

  task automatic test_down_expire();
    cyc(0, 1, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0);
    total++; if (sel !== 2'd2) begin bad++; $display("FAIL dn_sel got %0d want 2", sel); end
    set_field(0, 2);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    total++; if (disp_time !== 24'd1) begin bad++; $display("FAIL dn_tick1 got %h want 1", disp_time); end
    total++; if (expired !== 4'd0) begin bad++; $display("FAIL dn_tick1_exp got %b want 0000", expired); end
    cyc(1, 0, 0, 0, 0, 0, 0);
    total++; if (disp_time !== 24'd0) begin bad++; $display("FAIL dn_zero got %h want 0", disp_time); end
    total++; if (running[2] !== 1'b0) begin bad++; $display("FAIL dn_stop got %b want 0", running[2]); end
    total++; if (expired !== 4'b0100) begin bad++; $display("FAIL dn_exp got %b want 0100", expired); end
    cyc(0, 0, 0, 0, 0, 0, 0);
    total++; if (expired !== 4'd0) begin bad++; $display("FAIL dn_exp_len got %b want 0000", expired); end
    cyc(0, 0, 1, 0, 0, 0, 0);
    total++; if (running[2] !== 1'b0) begin bad++; $display("FAIL dn_zero_toggle got %b want 0", running[2]); end
  endtask

  task automatic test_field_edit();
    cyc(0, 1, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0);
    total++; if (sel !== 2'd1) begin bad++; $display("FAIL ed_sel got %0d want 1", sel); end
    set_field(1, 55);
    cyc(0, 0, 0, 0, 0, 1, 1);
    total++; if (disp_time !== {5'd0, 6'd0, 6'd5, 7'd0})
      begin bad++; $display("FAIL ed_sec_wrap got %h want %h", disp_time, {5'd0, 6'd0, 6'd5, 7'd0}); end
    set_field(0, 95);
    cyc(0, 0, 0, 0, 1, 1, 0);
    total++; if (disp_time !== {5'd0, 6'd0, 6'd5, 7'd6})
      begin bad++; $display("FAIL ed_sub_wrap got %h want %h", disp_time, {5'd0, 6'd0, 6'd5, 7'd6}); end
    set_field(3, 20);
    cyc(0, 0, 0, 0, 0, 1, 3);
    total++; if (disp_time !== {5'd6, 6'd0, 6'd5, 7'd6})
      begin bad++; $display("FAIL ed_hr_wrap got %h want %h", disp_time, {5'd6, 6'd0, 6'd5, 7'd6}); end
  endtask

  task automatic test_selector();
    for (int i = 1; i <= 4; i++) begin
      cyc(0, 1, 0, 0, 0, 0, 0);
      total++; if (sel !== 2'((1 + i) % 4))
        begin bad++; $display("FAIL sel_step%0d got %0d want %0d", i, sel, (1 + i) % 4); end
    end
    cyc(0, 1, 0, 0, 0, 0, 0);
    set_field(0, 7);
    cyc(0, 1, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 1, 0, 0, 0);
    total++; if (sel !== 2'd2) begin bad++; $display("FAIL selclr_sel got %0d want 2", sel); end
    total++; if (disp_time !== 24'd7) begin bad++; $display("FAIL selclr_new got %h want 7", disp_time); end
    cyc(0, 1, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0);
    total++; if (disp_time !== 24'd0) begin bad++; $display("FAIL selclr_old got %h want 0", disp_time); end
    set_field(0, 3);
    cyc(0, 0, 1, 1, 0, 0, 0);
    total++; if (running[1] !== 1'b0) begin bad++; $display("FAIL clrrun_run got %b want 0", running[1]); end
    total++; if (disp_time !== 24'd0) begin bad++; $display("FAIL clrrun_val got %h want 0", disp_time); end
  endtask

  task automatic test_lockout_parallel();
    cyc(0, 1, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    total++; if (disp_time !== 24'd0) begin bad++; $display("FAIL lock_edit got %h want 0", disp_time); end
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 0, 0, 0, 0, 0);
      total++; if (running !== 4'b1001) begin bad++; $display("FAIL par_run%0d got %b want 1001", i, running); end
    end
    cyc(0, 1, 0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0, 0, 0);
    total++; if (disp_time !== 24'd5) begin bad++; $display("FAIL par_ch3 got %h want 5", disp_time); end
    cyc(0, 1, 0, 0, 0, 0, 0);
    total++; if (disp_time !== 24'd5) begin bad++; $display("FAIL par_ch0 got %h want 5", disp_time); end
    cyc(0, 0, 1, 0, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 1) == 0), ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
          ($urandom_range(0, 29) == 0), ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 3)));
      total++; if (sel !== 2'(msel)) begin bad++; $display("FAIL rnd_sel@%0d got %0d want %0d", n, sel, msel); end
      total++; if (disp_time !== pack_t(mt[msel]))
        begin bad++; $display("FAIL rnd_disp@%0d got %h want %h", n, disp_time, pack_t(mt[msel])); end
      total++; if (running !== run_v()) begin bad++; $display("FAIL rnd_run@%0d got %b want %b", n, running, run_v()); end
      total++; if (expired !== exp_v()) begin bad++; $display("FAIL rnd_exp@%0d got %b want %b", n, expired, exp_v()); end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 4 && msel != 0; k++) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    total++; if (disp_time !== 24'd2) begin bad++; $display("FAIL ar_pre got %h want 2", disp_time); end
    #2 reset = 0;
    #1;
    total++; if (sel !== 2'd0) begin bad++; $display("FAIL ar_sel got %0d want 0", sel); end
    total++; if (disp_time !== 24'd0) begin bad++; $display("FAIL ar_disp got %h want 0", disp_time); end
    total++; if (running !== 4'd0) begin bad++; $display("FAIL ar_run got %b want 0000", running); end
    total++; if (expired !== 4'd0) begin bad++; $display("FAIL ar_exp got %b want 0000", expired); end
    model_reset();
    @(negedge clk); reset = 1;
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    total++; if (disp_time !== 24'd1) begin bad++; $display("FAIL ar_resume got %h want 1", disp_time); end
    total++; if (running !== 4'b0001) begin bad++; $display("FAIL ar_resume_run got %b want 0001", running); end
  endtask

  initial begin
    test_reset();
    test_up_carry();
    test_down_expire();
    test_field_edit();
    test_selector();
    test_lockout_parallel();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
